// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The slave modport is the loader's view; master is the stream source / memory side.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    modport slave (
        input  rx_valid, rx_data, reload,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );

    modport master (
        output rx_valid, rx_data, reload,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader that fills the instruction memory and holds the core in
// reset until done. Define CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input logic               CLK,
    input logic               RST,
    imem_boot_loader_if.slave bus
);

    localparam logic [2:0] StLen0 = 3'd0;
    localparam logic [2:0] StLen1 = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StFin  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;
`ifdef CHECKSUM_EN
    localparam logic [2:0] StCsum = 3'd6;
    localparam logic [2:0] StCok  = 3'd7;
    localparam logic [2:0] StPost = StCsum;
`else
    localparam logic [2:0] StPost = StDone;
`endif
    localparam int unsigned MaxWords = 1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rdy_q, rdy_d;
    logic              accept;
    logic [31:0]       hdr_cnt;
`ifdef CHECKSUM_EN
    logic [7:0]        csum_q, csum_d, csum_nxt;
`endif

    assign accept  = bus.rx_valid && rdy_q;
    assign hdr_cnt = {{(32-CNT_W){1'b0}}, bus.rx_data, count_q[7:0]};
`ifdef CHECKSUM_EN
    assign csum_nxt = csum_q + bus.rx_data;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
`ifdef CHECKSUM_EN
        csum_d  = accept ? csum_nxt : csum_q;
`endif
        // Address advances the cycle after each strobe and saturates at the top word.
        if (we_q && (addr_q != {ADDR_W{1'b1}})) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            StLen0: begin
                if (accept) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    count_d = hdr_cnt[CNT_W-1:0];
                    if (hdr_cnt > MaxWords) begin
                        state_d = StErr;
                    end else if (hdr_cnt == 32'd0) begin
                        state_d = StPost;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (count_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_d = StFin;
                        end
                    end
                end
            end
            StFin: state_d = StPost;
`ifdef CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (csum_nxt == 8'h00) ? StCok : StErr;
                end
            end
            StCok: state_d = StDone;
`endif
            StDone, StErr: begin
                if (bus.reload) begin
                    state_d = StLen0;
                    count_d = '0;
                    idx_d   = 2'd0;
                    addr_d  = '0;
                    wdata_d = '0;
`ifdef CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            default: state_d = StLen0;
        endcase

        rdy_d = (state_d == StLen0) || (state_d == StLen1) || (state_d == StData);
`ifdef CHECKSUM_EN
        rdy_d = rdy_d || (state_d == StCsum);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StLen0;
            count_q <= '0;
            idx_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdy_q   <= rdy_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rdy_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = (state_q != StDone);
    assign bus.load_done  = (state_q == StDone);
    assign bus.load_err   = (state_q == StErr);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed and randomized bench for imem_boot_loader; expectations come from a stream-level
// model of the image format (header count, little-endian words, optional checksum).
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_W(8)) bus ();

    imem_boot_loader #(.ADDR_W(8), .CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

`ifdef CHECKSUM_EN
    localparam bit CsumOn = 1'b1;
`else
    localparam bit CsumOn = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  stim[$];
    logic [39:0] exp_w[$];
    logic [39:0] got[$];
    bit          exp_done;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) got.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: parse the whole stream as an image.
    task automatic model();
        int cnt;
        logic [7:0] sum;
        exp_w.delete();
        cnt = {stim[1], stim[0]};
        sum = 8'h00;
        foreach (stim[k]) sum = sum + stim[k];
        if (cnt > 256) begin
            exp_done = 1'b0;
        end else begin
            for (int k = 0; k < cnt; k++) begin
                exp_w.push_back({k[7:0], stim[5+4*k], stim[4+4*k], stim[3+4*k], stim[2+4*k]});
            end
            exp_done = CsumOn ? (sum == 8'h00) : 1'b1;
        end
    endtask

    task automatic add_csum();
        logic [7:0] sum;
        sum = 8'h00;
        foreach (stim[k]) sum = sum + stim[k];
        if (CsumOn) stim.push_back(8'h00 - sum);
    endtask

    // mode 0: valid held high, 1: toggling, 2: random
    task automatic send(input int from, input int to, input int mode);
        int  i;
        int  cyc;
        bit  ph;
        logic xfer;
        i = from; cyc = 0; ph = 1'b1;
        while (i < to && cyc < 5000) begin
            bus.rx_data  = stim[i];
            bus.rx_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
            ph = !ph;
            xfer = bus.rx_valid && bus.rx_ready;
            @(posedge clk); #1;
            if (xfer) i++;
            cyc++;
        end
        bus.rx_valid = 1'b0;
        check("bytes_sent", 64'(i), 64'(to));
    endtask

    task automatic settle();
        for (int k = 0; k < 20 && !(bus.load_done || bus.load_err); k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_image(input string tag);
        check({tag, "_nwrites"}, 64'(got.size()), 64'(exp_w.size()));
        for (int k = 0; k < got.size() && k < exp_w.size(); k++) begin
            check({tag, "_write"}, 64'(got[k]), 64'(exp_w[k]));
        end
        check({tag, "_done"}, 64'(bus.load_done), 64'(exp_done));
        check({tag, "_err"}, 64'(bus.load_err), 64'(!exp_done));
        check({tag, "_hold"}, 64'(bus.cpu_hold), 64'(!exp_done));
    endtask

    task automatic run_image(input string tag, input int mode);
        got.delete();
        model();
        send(0, stim.size(), mode);
        settle();
        compare_image(tag);
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
        check("reload_hold", 64'(bus.cpu_hold), 64'd1);
        check("reload_flags", 64'({bus.load_done, bus.load_err}), 64'd0);
        check("reload_addr", 64'(bus.imem_addr), 64'd0);
        check("reload_ready", 64'(bus.rx_ready), 64'd1);
    endtask

    task automatic base_stream();
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        add_csum();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.reload   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.rx_ready), 64'd0);
        check("rst_we", 64'(bus.imem_we), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_hold", 64'(bus.cpu_hold), 64'd1);
        check("rst_flags", 64'({bus.load_done, bus.load_err}), 64'd0);
        rst = 1'b0;
        check("rel_ready_low", 64'(bus.rx_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_ready_high", 64'(bus.rx_ready), 64'd1);

        // Full-rate two-word image with final-write timing.
        base_stream();
        got.delete();
        model();
        send(0, stim.size(), 0);
        check("fin_we", 64'(bus.imem_we), 64'(!CsumOn));
        check("fin_ready", 64'(bus.rx_ready), 64'd0);
        check("fin_notdone", 64'({bus.load_done, bus.cpu_hold}), 64'b01);
        @(posedge clk); #1;
        check("fin_done", 64'({bus.load_done, bus.cpu_hold}), 64'b10);
        compare_image("full_rate");

        // Toggling valid, with a reload mid-stream that must be ignored.
        do_reload();
        base_stream();
        got.delete();
        model();
        send(0, 5, 1);
        bus.reload = 1'b1;
        @(posedge clk); #1;
        bus.reload = 1'b0;
        check("midreload_ready", 64'(bus.rx_ready), 64'd1);
        check("midreload_hold", 64'(bus.cpu_hold), 64'd1);
        send(5, stim.size(), 1);
        settle();
        compare_image("toggle");

        // Count 257 overflows an 8-bit address space.
        do_reload();
        stim = '{8'h01, 8'h01};
        run_image("overflow", 0);
        check("overflow_ready", 64'(bus.rx_ready), 64'd0);

`ifdef CHECKSUM_EN
        do_reload();
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        run_image("csum_good", 0);
        do_reload();
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF4};
        run_image("csum_bad", 0);
        do_reload();
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        run_image("csum_retry", 0);
`else
        do_reload();
        stim = '{8'h00, 8'h00};
        run_image("zero_len", 0);
`endif

        // Reset in the middle of word 0.
        do_reload();
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        got.delete();
        send(0, 4, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 64'(bus.rx_ready), 64'd0);
        check("midrst_addr", 64'(bus.imem_addr), 64'd0);
        check("midrst_wdata", 64'(bus.imem_wdata), 64'd0);
        check("midrst_hold", 64'(bus.cpu_hold), 64'd1);
        check("midrst_nwrites", 64'(got.size()), 64'd0);
        @(posedge clk); #1;
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        add_csum();
        run_image("after_rst", 0);
        check("after_rst_word", 64'(got.size() > 0 ? got[0] : 40'h0), 64'h00DDCCBBAA);

        // Random images, occasionally with a corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            do_reload();
            cnt = $urandom_range(1, 8);
            stim = '{8'(cnt), 8'h00};
            for (int k = 0; k < 4 * cnt; k++) stim.push_back(8'($urandom));
            add_csum();
            if (CsumOn && $urandom_range(0, 3) == 0) stim[stim.size()-1] ^= 8'h01;
            run_image("random", 2);
        end

        // Exactly full memory: 256 words is legal and the last lands at the top address.
        do_reload();
        stim = '{8'h00, 8'h01};
        for (int k = 0; k < 1024; k++) stim.push_back(8'($urandom));
        add_csum();
        run_image("full_mem", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
